meta_decode: RTL and testbench

//  Metadata ingest/cache for the sparse accelerator. It sits between the DMA metadata stream and the block scheduler.

---
 rtl/meta_decode_pkg.sv | 41 ++++
 rtl/meta_crc8.sv | 22 ++
 rtl/meta_decode.sv | 202 ++++++++++++++++++++
 tb/tb_meta_decode.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/meta_decode_pkg.sv
// Shared types, error flag indices and CRC-8 helpers for the metadata decoder.
// Used by meta_decode and meta_crc8.
package meta_decode_pkg;

    localparam int META_DEPTH = 256;
    localparam int META_AW    = 8;
    localparam int META_DW    = 32;

    typedef enum logic [1:0] {
        META_ROW_PTR   = 2'b00,
        META_COL_IDX   = 2'b01,
        META_BLOCK_HDR = 2'b10,
        META_INVALID   = 2'b11
    } meta_type_e;

    localparam int FLG_BAD_TYPE  = 0;
    localparam int FLG_OVERFLOW  = 1;
    localparam int FLG_CRC       = 2;
    localparam int FLG_ROW_BOUND = 3;
    localparam int FLG_COL_BOUND = 4;
    localparam int FLG_W         = 5;

    localparam logic [7:0] CRC8_POLY = 8'h07;

    function automatic logic [7:0] crc8_step(
        input logic [7:0] crc,
        input logic [7:0] data
    );
        logic [7:0] c;
        c = crc ^ data;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ({c[6:0], 1'b0} ^ CRC8_POLY) : {c[6:0], 1'b0};
        end
        return c;
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (&v) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/meta_crc8.sv
// Folds one 32-bit metadata word into a running CRC-8, most significant byte first.
// Purely combinational; the caller owns the CRC register.
module meta_crc8
    import meta_decode_pkg::*;
(
    input  logic [7:0]  crc_in,
    input  logic [31:0] word,
    output logic [7:0]  crc_out
);

    logic [7:0] c3;
    logic [7:0] c2;
    logic [7:0] c1;

    always_comb begin
        c3      = crc8_step(crc_in, word[31:24]);
        c2      = crc8_step(c3, word[23:16]);
        c1      = crc8_step(c2, word[15:8]);
        crc_out = crc8_step(c1, word[7:0]);
    end

endmodule

// File: rtl/meta_decode.sv
// Metadata ingest cache between the DMA metadata stream and the block scheduler.
// Optional bounds checking on ROW_PTR/COL_IDX: define META_DECODE_BOUNDS_CHECK_EN.
module meta_decode
    import meta_decode_pkg::*;
#(
    parameter int METADATA_CACHE_DEPTH  = META_DEPTH,
    parameter int METADATA_CACHE_ADDR_W = META_AW,
    parameter int DATA_WIDTH            = META_DW,
    parameter int ENABLE_CRC            = 1,
    parameter int ENABLE_PERF           = 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [DATA_WIDTH-1:0]            dma_meta_data,
    input  logic [DATA_WIDTH/8-1:0]          dma_meta_valid,
    input  logic [1:0]                       dma_meta_type,
    input  logic                             dma_meta_wen,
    output logic                             dma_meta_ready,
    input  logic [METADATA_CACHE_ADDR_W-1:0] sched_meta_raddr,
    input  logic                             sched_meta_ren,
    output logic [DATA_WIDTH-1:0]            sched_meta_rdata,
    output logic                             sched_meta_rvalid,
    input  logic [15:0]                      cfg_num_rows,
    input  logic [15:0]                      cfg_num_cols,
    input  logic [31:0]                      cfg_total_blocks,
    input  logic [2:0]                       cfg_block_size,
    output logic [31:0]                      perf_cache_hits,
    output logic [31:0]                      perf_cache_misses,
    output logic [31:0]                      perf_decode_cycles,
    output logic                             meta_error,
    output logic [31:0]                      meta_error_flags
);

    localparam int NB = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0]            mem [METADATA_CACHE_DEPTH];
    logic [METADATA_CACHE_DEPTH-1:0]  entry_vld;
    logic [METADATA_CACHE_ADDR_W-1:0] wr_ptr;
    logic [7:0]                       crc_q;
    logic [7:0]                       crc_next;
    logic [31:0]                      stored_cnt;
    logic [FLG_W-1:0]                 flags_q;
    logic [FLG_W-1:0]                 flag_set;

    meta_type_e mtype;
    logic       accept;
    logic       is_store;
    logic       is_hdr;
    logic       is_bad;
    logic       wr_en;
    logic       hdr_en;
    logic       bad_en;
    logic       rd_hit;
    logic       row_flag;
    logic       col_flag;

    assign dma_meta_ready = ~rst;
    assign accept         = dma_meta_wen & dma_meta_ready;
    assign mtype          = meta_type_e'(dma_meta_type);

    always_comb begin
        is_store = 1'b0;
        is_hdr   = 1'b0;
        is_bad   = 1'b0;
        unique case (1'b1)
            mtype == META_ROW_PTR,
            mtype == META_COL_IDX: is_store = 1'b1;
            mtype == META_BLOCK_HDR: begin
                if (ENABLE_CRC != 0) is_hdr = 1'b1;
                else                 is_store = 1'b1;
            end
            default: is_bad = 1'b1;
        endcase
    end

    assign wr_en  = accept & is_store;
    assign hdr_en = accept & is_hdr;
    assign bad_en = accept & is_bad;
    assign rd_hit = entry_vld[sched_meta_raddr];

    meta_crc8 u_crc (
        .crc_in  (crc_q),
        .word    (dma_meta_data[31:0]),
        .crc_out (crc_next)
    );

    // Cache storage carries no reset; entry_vld alone decides visibility.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < NB; i++) begin
                if (dma_meta_valid[i]) begin
                    mem[wr_ptr][8*i +: 8] <= dma_meta_data[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            entry_vld  <= '0;
            crc_q      <= '0;
            stored_cnt <= '0;
        end else begin
            if (wr_en) begin
                entry_vld[wr_ptr] <= 1'b1;
                wr_ptr            <= wr_ptr + 1'b1;
                crc_q             <= crc_next;
                stored_cnt        <= sat_inc(stored_cnt);
            end else if (hdr_en) begin
                crc_q <= '0;
            end
        end
    end

    // Reads see the pre-write contents when they collide with a write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sched_meta_rdata  <= '0;
            sched_meta_rvalid <= 1'b0;
        end else if (sched_meta_ren) begin
            sched_meta_rvalid <= rd_hit;
            sched_meta_rdata  <= rd_hit ? mem[sched_meta_raddr] : '0;
        end else begin
            sched_meta_rvalid <= 1'b0;
        end
    end

`ifdef META_DECODE_BOUNDS_CHECK_EN
    logic [16:0] row_cnt;
    logic [16:0] row_lim;
    logic        row_wr;
    logic        unused_cfg;

    assign row_wr     = wr_en && (mtype == META_ROW_PTR);
    assign row_lim    = {1'b0, cfg_num_rows} + 17'd1;
    assign unused_cfg = ^cfg_block_size;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_cnt <= '0;
        end else if (row_wr && !(&row_cnt)) begin
            row_cnt <= row_cnt + 17'd1;
        end
    end

    // Count after this write exceeds the limit when the count before reaches it.
    assign row_flag = row_wr && (row_cnt >= row_lim);
    assign col_flag = wr_en && (mtype == META_COL_IDX)
                    && (dma_meta_data[15:0] >= cfg_num_cols);
`else
    logic unused_cfg;

    assign unused_cfg = ^{cfg_block_size, cfg_num_rows, cfg_num_cols};
    assign row_flag   = 1'b0;
    assign col_flag   = 1'b0;
`endif

    always_comb begin
        flag_set                = '0;
        flag_set[FLG_BAD_TYPE]  = bad_en;
        flag_set[FLG_OVERFLOW]  = wr_en && (stored_cnt >= cfg_total_blocks);
        flag_set[FLG_CRC]       = hdr_en && (dma_meta_data[7:0] != crc_q);
        flag_set[FLG_ROW_BOUND] = row_flag;
        flag_set[FLG_COL_BOUND] = col_flag;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) flags_q <= '0;
        else     flags_q <= flags_q | flag_set;
    end

    assign meta_error_flags = {{(32-FLG_W){1'b0}}, flags_q};
    assign meta_error       = |flags_q;

    if (ENABLE_PERF != 0) begin : g_perf
        logic [31:0] hits_q;
        logic [31:0] misses_q;
        logic [31:0] cycles_q;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                hits_q   <= '0;
                misses_q <= '0;
                cycles_q <= '0;
            end else begin
                if (sched_meta_ren && rd_hit)  hits_q   <= sat_inc(hits_q);
                if (sched_meta_ren && !rd_hit) misses_q <= sat_inc(misses_q);
                if (accept)                    cycles_q <= sat_inc(cycles_q);
            end
        end

        assign perf_cache_hits    = hits_q;
        assign perf_cache_misses  = misses_q;
        assign perf_decode_cycles = cycles_q;
    end else begin : g_no_perf
        assign perf_cache_hits    = '0;
        assign perf_cache_misses  = '0;
        assign perf_decode_cycles = '0;
    end

endmodule

// File: tb/tb_meta_decode.sv
// Directed bench for meta_decode with a read scoreboard and a reference model.
// Default build: bounds checking disabled.
module tb_meta_decode;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] dma_meta_data;
    logic [3:0]  dma_meta_valid;
    logic [1:0]  dma_meta_type;
    logic        dma_meta_wen;
    logic        dma_meta_ready;
    logic [7:0]  sched_meta_raddr;
    logic        sched_meta_ren;
    logic [31:0] sched_meta_rdata;
    logic        sched_meta_rvalid;
    logic [15:0] cfg_num_rows;
    logic [15:0] cfg_num_cols;
    logic [31:0] cfg_total_blocks;
    logic [2:0]  cfg_block_size;
    logic [31:0] perf_cache_hits;
    logic [31:0] perf_cache_misses;
    logic [31:0] perf_decode_cycles;
    logic        meta_error;
    logic [31:0] meta_error_flags;

    meta_decode dut (
        .clk                (clk),
        .rst                (rst),
        .dma_meta_data      (dma_meta_data),
        .dma_meta_valid     (dma_meta_valid),
        .dma_meta_type      (dma_meta_type),
        .dma_meta_wen       (dma_meta_wen),
        .dma_meta_ready     (dma_meta_ready),
        .sched_meta_raddr   (sched_meta_raddr),
        .sched_meta_ren     (sched_meta_ren),
        .sched_meta_rdata   (sched_meta_rdata),
        .sched_meta_rvalid  (sched_meta_rvalid),
        .cfg_num_rows       (cfg_num_rows),
        .cfg_num_cols       (cfg_num_cols),
        .cfg_total_blocks   (cfg_total_blocks),
        .cfg_block_size     (cfg_block_size),
        .perf_cache_hits    (perf_cache_hits),
        .perf_cache_misses  (perf_cache_misses),
        .perf_decode_cycles (perf_decode_cycles),
        .meta_error         (meta_error),
        .meta_error_flags   (meta_error_flags)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_mem [256];
    bit          m_vld [256];
    int          m_wp;
    logic [7:0]  m_crc;
    int          m_hits;
    int          m_miss;
    int          m_dec;
    logic [31:0] m_flags;
    int          m_stored;
    logic [31:0] last_rdata;
    logic [32:0] sb [$];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Bit-serial CRC-8 (poly 0x07), MSB first.
    function automatic logic [7:0] ref_crc(input logic [7:0] c,
                                           input logic [31:0] w);
        logic fb;
        for (int i = 31; i >= 0; i--) begin
            fb = c[7] ^ w[i];
            c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
        end
        return c;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset;
        for (int i = 0; i < 256; i++) begin
            m_vld[i] = 1'b0;
            m_mem[i] = '0;
        end
        m_wp = 0; m_crc = '0; m_hits = 0; m_miss = 0;
        m_dec = 0; m_flags = '0; m_stored = 0;
        last_rdata = '0;
        sb.delete();
    endtask

    task automatic wr(input logic [1:0] t, input logic [31:0] d,
                      input logic [3:0] be);
        dma_meta_type  = t;
        dma_meta_data  = d;
        dma_meta_valid = be;
        dma_meta_wen   = 1'b1;
        tick();
        dma_meta_wen   = 1'b0;
        m_dec++;
        if (t == 2'b11) begin
            m_flags[0] = 1'b1;
        end else if (t == 2'b10) begin
            if (d[7:0] != m_crc) m_flags[2] = 1'b1;
            m_crc = '0;
        end else begin
            if (m_stored >= int'(cfg_total_blocks)) m_flags[1] = 1'b1;
            m_stored++;
            for (int b = 0; b < 4; b++)
                if (be[b]) m_mem[m_wp][8*b +: 8] = d[8*b +: 8];
            m_vld[m_wp] = 1'b1;
            m_crc = ref_crc(m_crc, d);
            m_wp  = (m_wp + 1) % 256;
        end
    endtask

    task automatic rd(input int a);
        logic [32:0] e;
        sched_meta_ren   = 1'b1;
        sched_meta_raddr = 8'(a);
        sb.push_back({m_vld[a], m_vld[a] ? m_mem[a] : 32'h0});
        if (m_vld[a]) m_hits++;
        else          m_miss++;
        tick();
        e = sb.pop_front();
        chk($sformatf("rvalid[%0d]", a), {31'h0, sched_meta_rvalid},
            {31'h0, e[32]});
        chk($sformatf("rdata[%0d]", a), sched_meta_rdata, e[31:0]);
        if (e[32]) last_rdata = e[31:0];
        else       last_rdata = '0;
    endtask

    task automatic chk_state(input string tag);
        chk({tag, ".flags"}, meta_error_flags, m_flags);
        chk({tag, ".err"}, {31'h0, meta_error}, {31'h0, |m_flags});
        chk({tag, ".hits"}, perf_cache_hits, m_hits);
        chk({tag, ".miss"}, perf_cache_misses, m_miss);
        chk({tag, ".dec"}, perf_decode_cycles, m_dec);
    endtask

    initial begin
        rst = 1'b1;
        dma_meta_data = '0; dma_meta_valid = '0; dma_meta_type = '0;
        dma_meta_wen = 1'b0; sched_meta_raddr = '0; sched_meta_ren = 1'b0;
        cfg_num_rows = 16'd300; cfg_num_cols = 16'hFFFF;
        cfg_total_blocks = 32'd1000; cfg_block_size = 3'd2;
        model_reset();

        chk("crc_const", {24'h0, ref_crc(8'h00, 32'h0000_0001)}, 32'h07);
        tick(); tick();
        chk("rst.ready", {31'h0, dma_meta_ready}, 32'h0);
        chk("rst.rvalid", {31'h0, sched_meta_rvalid}, 32'h0);
        chk("rst.rdata", sched_meta_rdata, 32'h0);
        chk_state("rst");
        rst = 1'b0;
        tick();
        chk("ready", {31'h0, dma_meta_ready}, 32'h1);

        for (int i = 0; i < 10; i++)
            wr(2'b00, 32'h1000_0000 + (i << 4), 4'hF);
        for (int i = 0; i < 10; i++) rd(i % 5);
        sched_meta_ren = 1'b0;
        tick();
        chk("idle.rvalid", {31'h0, sched_meta_rvalid}, 32'h0);
        chk("idle.rdata", sched_meta_rdata, last_rdata);
        chk("hits10", perf_cache_hits, 32'd10);

        rd(200);
        sched_meta_ren = 1'b0;
        chk("miss1", perf_cache_misses, 32'd1);

        for (int i = 0; i < 8; i++) wr(2'b01, 32'hAAAA_0000 + i, 4'hF);
        chk("dec18", perf_decode_cycles, 32'd18);
        for (int i = 10; i < 18; i++) rd(i);
        sched_meta_ren = 1'b0;
        chk_state("col");

        wr(2'b11, 32'hFFFF_FFFF, 4'hF);
        chk("badtype.flags", meta_error_flags, 32'h1);
        chk("badtype.err", {31'h0, meta_error}, 32'h1);
        wr(2'b00, 32'h55AA_0018, 4'hF);
        rd(18);
        rd(19);
        sched_meta_ren = 1'b0;

        wr(2'b10, {24'hABCDEF, m_crc}, 4'hF);
        chk("crc_ok.flags", meta_error_flags, 32'h1);
        wr(2'b01, 32'h0000_0001, 4'hF);
        wr(2'b10, {24'h0, ~m_crc}, 4'hF);
        chk("crc_bad.flags", meta_error_flags, 32'h5);
        wr(2'b01, 32'h0000_0002, 4'hF);
        rd(20);
        rd(21);
        sched_meta_ren = 1'b0;
        chk_state("crc");

        while (m_wp != 0) wr(2'b01, 32'hC000_0000 | m_wp, 4'hF);
        wr(2'b00, 32'hDEAD_BEEF, 4'b0101);
        rd(0);
        rd(255);
        rd(1);
        sched_meta_ren = 1'b0;
        chk("wrap.merge", last_rdata, 32'h1000_0010);
        chk_state("wrap");

        dma_meta_type = 2'b00; dma_meta_data = 32'h1234_5678;
        dma_meta_valid = 4'hF; dma_meta_wen = 1'b1;
        #2 rst = 1'b1;
        #1;
        model_reset();
        chk("arst.rvalid", {31'h0, sched_meta_rvalid}, 32'h0);
        chk("arst.rdata", sched_meta_rdata, 32'h0);
        chk_state("arst");
        tick();
        dma_meta_wen = 1'b0;
        rst = 1'b0;
        tick();

        cfg_total_blocks = 32'd4;
        for (int i = 0; i < 4; i++) wr(2'b00, 32'h2000_0000 + i, 4'hF);
        chk("ovf4.flags", meta_error_flags, 32'h0);
        wr(2'b01, 32'h0000_0005, 4'hF);
        chk("ovf5.flags", meta_error_flags, 32'h2);
        rd(4);
        sched_meta_ren = 1'b0;
        chk_state("ovf");

        rst = 1'b1;
        tick();
        model_reset();
        chk_state("rst2");
        rst = 1'b0;
        tick();
        rd(0);
        sched_meta_ren = 1'b0;
        chk_state("post");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
